// File: rtl/msi_axi_write_responder_if.sv
// AXI write-channel bundle for the MSI responder (AW, W, B).
// master drives requests; slave answers with ready/response.
interface msi_axi_write_responder_if;
  logic [63:0]  SLAVE_AXI_AWADDR;
  logic [7:0]   SLAVE_AXI_AWID;
  logic [7:0]   SLAVE_AXI_AWLEN;
  logic [2:0]   SLAVE_AXI_AWSIZE;
  logic         SLAVE_AXI_AWVALID;
  logic         SLAVE_AXI_AWREADY;
  logic [255:0] SLAVE_AXI_WDATA;
  logic [31:0]  SLAVE_AXI_WDATA_PAR;
  logic [31:0]  SLAVE_AXI_WSTRB;
  logic [3:0]   SLAVE_AXI_WSTRB_PAR;
  logic         SLAVE_AXI_WLAST;
  logic         SLAVE_AXI_WVALID;
  logic         SLAVE_AXI_WREADY;
  logic [7:0]   SLAVE_AXI_BID;
  logic         SLAVE_AXI_BID_PAR;
  logic [1:0]   SLAVE_AXI_BRESP;
  logic         SLAVE_AXI_BRESP_PAR;
  logic         SLAVE_AXI_BVALID;
  logic         SLAVE_AXI_BREADY;

  modport master (
    output SLAVE_AXI_AWADDR, SLAVE_AXI_AWID,
    output SLAVE_AXI_AWLEN, SLAVE_AXI_AWSIZE,
    output SLAVE_AXI_AWVALID,
    input  SLAVE_AXI_AWREADY,
    output SLAVE_AXI_WDATA, SLAVE_AXI_WDATA_PAR,
    output SLAVE_AXI_WSTRB, SLAVE_AXI_WSTRB_PAR,
    output SLAVE_AXI_WLAST, SLAVE_AXI_WVALID,
    input  SLAVE_AXI_WREADY,
    input  SLAVE_AXI_BID, SLAVE_AXI_BID_PAR,
    input  SLAVE_AXI_BRESP, SLAVE_AXI_BRESP_PAR,
    input  SLAVE_AXI_BVALID,
    output SLAVE_AXI_BREADY
  );

  modport slave (
    input  SLAVE_AXI_AWADDR, SLAVE_AXI_AWID,
    input  SLAVE_AXI_AWLEN, SLAVE_AXI_AWSIZE,
    input  SLAVE_AXI_AWVALID,
    output SLAVE_AXI_AWREADY,
    input  SLAVE_AXI_WDATA, SLAVE_AXI_WDATA_PAR,
    input  SLAVE_AXI_WSTRB, SLAVE_AXI_WSTRB_PAR,
    input  SLAVE_AXI_WLAST, SLAVE_AXI_WVALID,
    output SLAVE_AXI_WREADY,
    output SLAVE_AXI_BID, SLAVE_AXI_BID_PAR,
    output SLAVE_AXI_BRESP, SLAVE_AXI_BRESP_PAR,
    output SLAVE_AXI_BVALID,
    input  SLAVE_AXI_BREADY
  );
endinterface

// File: rtl/msi_axi_write_responder.sv
// AXI write slave terminating single-beat MSI writes into an event FIFO.
// Define MSI_PARITY_CHECK_EN to reject writes with WDATA/WSTRB parity errors.
module msi_axi_write_responder #(
  parameter logic [31:0] MSI_BASE_ADDR = 32'hFEE0_0000,
  parameter logic [31:0] MSI_ADDR_MASK = 32'hFFF0_0000,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  msi_axi_write_responder_if.slave s_axi,
  output logic                 msi_valid,
  input  logic                 msi_ready,
  output logic [15:0]          msi_data,
  output logic [31:0]          msi_addr,
  output logic [CNT_WIDTH-1:0] msi_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [1:0]           state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_W = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e st_q, st_d;

  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [7:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;

  logic [15:0] fdata_q [FIFO_DEPTH];
  logic [15:0] fdata_d [FIFO_DEPTH];
  logic [31:0] faddr_q [FIFO_DEPTH];
  logic [31:0] faddr_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   fcnt_q, fcnt_d;

  logic [CNT_WIDTH-1:0] msi_cnt_q, msi_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic        aw_hs, w_hs, b_hs;
  logic        push, pop;
  logic        bad, par_err;
  logic [4:0]  off;
  logic [31:0] exp_strb;
  logic [15:0] payload;

  assign aw_hs = (st_q == IDLE) && awready_q &&
                 s_axi.SLAVE_AXI_AWVALID;
  assign w_hs  = (st_q == WAIT_W) && wready_q &&
                 s_axi.SLAVE_AXI_WVALID;
  assign b_hs  = (st_q == RESP) && bvalid_q &&
                 s_axi.SLAVE_AXI_BREADY;

  assign off      = addr_q[4:0];
  assign exp_strb = 32'h3 << off;
  assign payload  = 16'(s_axi.SLAVE_AXI_WDATA >> {off, 3'b000});

`ifdef MSI_PARITY_CHECK_EN
  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (s_axi.SLAVE_AXI_WSTRB[i] &&
          (s_axi.SLAVE_AXI_WDATA_PAR[i] !=
           ~^s_axi.SLAVE_AXI_WDATA[8*i +: 8]))
        par_err = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      if (s_axi.SLAVE_AXI_WSTRB_PAR[j] !=
          ~^s_axi.SLAVE_AXI_WSTRB[8*j +: 8])
        par_err = 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^s_axi.SLAVE_AXI_AWADDR[63:32];
`else
  assign par_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{s_axi.SLAVE_AXI_AWADDR[63:32],
                       s_axi.SLAVE_AXI_WDATA_PAR,
                       s_axi.SLAVE_AXI_WSTRB_PAR};
`endif

  assign bad = ((addr_q & MSI_ADDR_MASK) != MSI_BASE_ADDR) ||
               (len_q != 8'd0) ||
               (size_q != 3'd5) ||
               !s_axi.SLAVE_AXI_WLAST ||
               (off == 5'd31) ||
               (s_axi.SLAVE_AXI_WSTRB != exp_strb) ||
               par_err;

  assign push = w_hs && !bad;
  assign pop  = (fcnt_q != '0) && msi_ready;

  always_comb begin
    fdata_d = fdata_q;
    faddr_d = faddr_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fcnt_d  = fcnt_q;
    if (push) begin
      fdata_d[wptr_q] = payload;
      faddr_d[wptr_q] = addr_q;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (PW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    msi_cnt_d = msi_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      msi_cnt_d = msi_cnt_q + CNT_WIDTH'(1);
    end
    // error counter saturates so a storm stays visible
    if (w_hs && bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    st_d     = st_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    addr_d   = addr_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    unique case (st_q)
      IDLE: begin
        if (aw_hs) begin
          addr_d = s_axi.SLAVE_AXI_AWADDR[31:0];
          id_d   = s_axi.SLAVE_AXI_AWID;
          len_d  = s_axi.SLAVE_AXI_AWLEN;
          size_d = s_axi.SLAVE_AXI_AWSIZE;
          st_d   = WAIT_W;
        end
      end
      WAIT_W: begin
        if (w_hs) begin
          bvalid_d = 1'b1;
          bid_d    = id_q;
          bresp_d  = bad ? 2'b10 : 2'b00;
          st_d     = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          st_d     = IDLE;
        end
      end
      default: begin
        bvalid_d = 1'b0;
        st_d     = IDLE;
      end
    endcase
    // space can only grow while idle, so this never over-admits
    awready_d = (st_d == IDLE) && (fcnt_d < DEPTH_C);
    wready_d  = (st_d == WAIT_W);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q      <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      msi_cnt_q <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata_q[i] <= '0;
        faddr_q[i] <= '0;
      end
    end else begin
      st_q      <= st_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      size_q    <= size_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      msi_cnt_q <= msi_cnt_d;
      err_cnt_q <= err_cnt_d;
      fdata_q   <= fdata_d;
      faddr_q   <= faddr_d;
    end
  end

  assign s_axi.SLAVE_AXI_AWREADY   = awready_q;
  assign s_axi.SLAVE_AXI_WREADY    = wready_q;
  assign s_axi.SLAVE_AXI_BVALID    = bvalid_q;
  assign s_axi.SLAVE_AXI_BID       = bid_q;
  assign s_axi.SLAVE_AXI_BRESP     = bresp_q;
  assign s_axi.SLAVE_AXI_BID_PAR   = ~^bid_q;
  assign s_axi.SLAVE_AXI_BRESP_PAR = ~^bresp_q;

  assign msi_valid = (fcnt_q != '0);
  assign msi_data  = fdata_q[rptr_q];
  assign msi_addr  = faddr_q[rptr_q];
  assign msi_cnt   = msi_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign state     = st_q;

endmodule

// File: tb/tb_msi_axi_write_responder.sv
// Scoreboard bench for msi_axi_write_responder.
// Honours MSI_PARITY_CHECK_EN to pick the parity-test expectation.
module tb_msi_axi_write_responder;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  msi_axi_write_responder_if ifc ();

  logic        msi_valid;
  logic        msi_ready;
  logic [15:0] msi_data;
  logic [31:0] msi_addr;
  logic [15:0] msi_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  msi_axi_write_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_axi     (ifc.slave),
    .msi_valid (msi_valid),
    .msi_ready (msi_ready),
    .msi_data  (msi_data),
    .msi_addr  (msi_addr),
    .msi_cnt   (msi_cnt),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } mexp_t;

  bexp_t bq[$];
  mexp_t mq[$];
  int total  = 0;
  int passed = 0;
  logic [15:0] m_msi = '0;
  logic [15:0] m_err = '0;

  function automatic logic [31:0] dpar(input logic [255:0] d);
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = ~^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [3:0] spar(input logic [31:0] s);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ~^s[8*i +: 8];
    return p;
  endfunction

  task automatic bus_idle();
    ifc.SLAVE_AXI_AWADDR    = '0;
    ifc.SLAVE_AXI_AWID      = '0;
    ifc.SLAVE_AXI_AWLEN     = '0;
    ifc.SLAVE_AXI_AWSIZE    = '0;
    ifc.SLAVE_AXI_AWVALID   = 1'b0;
    ifc.SLAVE_AXI_WDATA     = '0;
    ifc.SLAVE_AXI_WDATA_PAR = '0;
    ifc.SLAVE_AXI_WSTRB     = '0;
    ifc.SLAVE_AXI_WSTRB_PAR = '0;
    ifc.SLAVE_AXI_WLAST     = 1'b0;
    ifc.SLAVE_AXI_WVALID    = 1'b0;
    ifc.SLAVE_AXI_BREADY    = 1'b0;
    msi_ready               = 1'b0;
  endtask

  // bmode: 0 = BREADY at once, 1 = hold off 10 cycles, 2 = reset in RESP
  task automatic do_write(input logic [31:0] addr,
                          input logic [7:0] id,
                          input logic [7:0] len,
                          input logic [2:0] sz,
                          input logic [255:0] data,
                          input logic [31:0] strb,
                          input logic last,
                          input logic [31:0] pflip,
                          input bit ok,
                          input int bmode);
    bexp_t be;
    int n;
    bit stable;
    be.id   = id;
    be.resp = ok ? 2'b00 : 2'b10;
    bq.push_back(be);
    if (ok) begin
      mq.push_back('{addr: addr, data: 16'(data >> (addr[4:0] * 8))});
      m_msi = m_msi + 16'd1;
    end else if (m_err != 16'hFFFF) begin
      m_err = m_err + 16'd1;
    end
    ifc.SLAVE_AXI_AWADDR  = {32'h0, addr};
    ifc.SLAVE_AXI_AWID    = id;
    ifc.SLAVE_AXI_AWLEN   = len;
    ifc.SLAVE_AXI_AWSIZE  = sz;
    ifc.SLAVE_AXI_AWVALID = 1'b1;
    n = 0;
    while (ifc.SLAVE_AXI_AWREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.SLAVE_AXI_AWREADY !== 1'b1) begin
      $display("FAIL aw_timeout awready=%b required 1",
               ifc.SLAVE_AXI_AWREADY);
      bus_idle();
      return;
    end
    passed++;
    @(negedge clk);
    ifc.SLAVE_AXI_AWVALID   = 1'b0;
    ifc.SLAVE_AXI_WDATA     = data;
    ifc.SLAVE_AXI_WDATA_PAR = dpar(data) ^ pflip;
    ifc.SLAVE_AXI_WSTRB     = strb;
    ifc.SLAVE_AXI_WSTRB_PAR = spar(strb);
    ifc.SLAVE_AXI_WLAST     = last;
    ifc.SLAVE_AXI_WVALID    = 1'b1;
    n = 0;
    while (ifc.SLAVE_AXI_WREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.SLAVE_AXI_WREADY !== 1'b1) begin
      $display("FAIL w_timeout wready=%b required 1",
               ifc.SLAVE_AXI_WREADY);
      bus_idle();
      return;
    end
    passed++;
    @(negedge clk);
    ifc.SLAVE_AXI_WVALID = 1'b0;
    n = 0;
    while (ifc.SLAVE_AXI_BVALID !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    be = bq.pop_front();
    total++;
    if (ifc.SLAVE_AXI_BVALID !== 1'b1 ||
        ifc.SLAVE_AXI_BID !== be.id ||
        ifc.SLAVE_AXI_BRESP !== be.resp ||
        ifc.SLAVE_AXI_BID_PAR !== ~^be.id ||
        ifc.SLAVE_AXI_BRESP_PAR !== ~^be.resp)
      $display("FAIL bresp got v=%b id=%h r=%b ip=%b rp=%b required v=1 id=%h r=%b ip=%b rp=%b",
               ifc.SLAVE_AXI_BVALID, ifc.SLAVE_AXI_BID,
               ifc.SLAVE_AXI_BRESP, ifc.SLAVE_AXI_BID_PAR,
               ifc.SLAVE_AXI_BRESP_PAR, be.id, be.resp,
               ~^be.id, ~^be.resp);
    else passed++;
    total++;
    if (msi_cnt !== m_msi || err_cnt !== m_err)
      $display("FAIL counters got msi=%0d err=%0d required msi=%0d err=%0d",
               msi_cnt, err_cnt, m_msi, m_err);
    else passed++;
    if (bmode == 1) begin
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (ifc.SLAVE_AXI_BVALID !== 1'b1 ||
            ifc.SLAVE_AXI_BID !== be.id ||
            ifc.SLAVE_AXI_BRESP !== be.resp)
          stable = 1'b0;
      end
      total++;
      if (!stable)
        $display("FAIL b_hold got v=%b id=%h r=%b required v=1 id=%h r=%b",
                 ifc.SLAVE_AXI_BVALID, ifc.SLAVE_AXI_BID,
                 ifc.SLAVE_AXI_BRESP, be.id, be.resp);
      else passed++;
    end
    if (bmode == 2) begin
      rstn = 1'b0;
      @(negedge clk);
      mq.delete();
      m_msi = '0;
      m_err = '0;
      total++;
      if (ifc.SLAVE_AXI_BVALID !== 1'b0 || msi_valid !== 1'b0 ||
          state !== 2'd0 || msi_cnt !== 16'd0)
        $display("FAIL reset_in_resp got bv=%b mv=%b st=%0d cnt=%0d required bv=0 mv=0 st=0 cnt=0",
                 ifc.SLAVE_AXI_BVALID, msi_valid, state, msi_cnt);
      else passed++;
      rstn = 1'b1;
      @(negedge clk);
      return;
    end
    ifc.SLAVE_AXI_BREADY = 1'b1;
    @(negedge clk);
    ifc.SLAVE_AXI_BREADY = 1'b0;
    total++;
    if (ifc.SLAVE_AXI_BVALID !== 1'b0 || state !== 2'd0)
      $display("FAIL b_release got bv=%b st=%0d required bv=0 st=0",
               ifc.SLAVE_AXI_BVALID, state);
    else passed++;
  endtask

  task automatic pop_check(input string tag);
    mexp_t me;
    if (mq.size() == 0) begin
      total++;
      $display("FAIL %s scoreboard_empty", tag);
      return;
    end
    me = mq.pop_front();
    total++;
    if (msi_valid !== 1'b1 || msi_data !== me.data ||
        msi_addr !== me.addr)
      $display("FAIL %s got v=%b d=%h a=%h required v=1 d=%h a=%h",
               tag, msi_valid, msi_data, msi_addr, me.data, me.addr);
    else passed++;
    msi_ready = 1'b1;
    @(negedge clk);
    msi_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus_idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ifc.SLAVE_AXI_AWREADY !== 1'b0 || ifc.SLAVE_AXI_WREADY !== 1'b0 ||
        ifc.SLAVE_AXI_BVALID !== 1'b0 || ifc.SLAVE_AXI_BID !== 8'h0 ||
        ifc.SLAVE_AXI_BRESP !== 2'b00 ||
        ifc.SLAVE_AXI_BID_PAR !== 1'b1 ||
        ifc.SLAVE_AXI_BRESP_PAR !== 1'b1)
      $display("FAIL reset_axi got aw=%b w=%b bv=%b bid=%h br=%b ip=%b rp=%b required 0 0 0 00 00 1 1",
               ifc.SLAVE_AXI_AWREADY, ifc.SLAVE_AXI_WREADY,
               ifc.SLAVE_AXI_BVALID, ifc.SLAVE_AXI_BID,
               ifc.SLAVE_AXI_BRESP, ifc.SLAVE_AXI_BID_PAR,
               ifc.SLAVE_AXI_BRESP_PAR);
    else passed++;
    total++;
    if (msi_valid !== 1'b0 || msi_data !== 16'h0 || msi_addr !== 32'h0 ||
        msi_cnt !== 16'h0 || err_cnt !== 16'h0 || state !== 2'd0)
      $display("FAIL reset_msi got v=%b d=%h a=%h mc=%0d ec=%0d st=%0d required all 0",
               msi_valid, msi_data, msi_addr, msi_cnt, err_cnt, state);
    else passed++;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.SLAVE_AXI_AWREADY !== 1'b1)
      $display("FAIL post_reset_awready got %b required 1",
               ifc.SLAVE_AXI_AWREADY);
    else passed++;
  endtask

  task automatic test_okay();
    logic [255:0] d;
    d = 256'hABCD << 32;
    do_write(32'hFEE0_0004, 8'h05, 8'd0, 3'd5, d, 32'h30,
             1'b1, 32'h0, 1'b1, 0);
    pop_check("okay_fifo");
    total++;
    if (msi_valid !== 1'b0)
      $display("FAIL okay_drain got v=%b required 0", msi_valid);
    else passed++;
  endtask

  task automatic test_bad_addr();
    logic [255:0] d;
    d = 256'h1234;
    do_write(32'h1000_0000, 8'h11, 8'd0, 3'd5, d, 32'h3,
             1'b1, 32'h0, 1'b0, 0);
    total++;
    if (msi_valid !== 1'b0)
      $display("FAIL bad_addr_push got v=%b required 0", msi_valid);
    else passed++;
  endtask

  task automatic test_fifo_full();
    logic [255:0] d;
    logic [31:0]  a;
    logic [15:0]  p;
    bit blocked;
    for (int i = 0; i < 5; i++) begin
      a = 32'hFEE0_0000 | 32'(i * 4);
      p = 16'h1000 + 16'(i);
      d = 256'(p) << (i * 32);
      if (i == 4) begin
        ifc.SLAVE_AXI_AWADDR  = {32'h0, a};
        ifc.SLAVE_AXI_AWID    = 8'(i);
        ifc.SLAVE_AXI_AWLEN   = 8'd0;
        ifc.SLAVE_AXI_AWSIZE  = 3'd5;
        ifc.SLAVE_AXI_AWVALID = 1'b1;
        blocked = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (ifc.SLAVE_AXI_AWREADY !== 1'b0) blocked = 1'b0;
        end
        total++;
        if (!blocked || state !== 2'd0)
          $display("FAIL full_block got awready=%b st=%0d required 0 0",
                   ifc.SLAVE_AXI_AWREADY, state);
        else passed++;
        pop_check("full_pop0");
      end
      do_write(a, 8'(i), 8'd0, 3'd5, d, 32'h3 << (i * 4),
               1'b1, 32'h0, 1'b1, 0);
    end
    for (int i = 1; i < 5; i++) pop_check("full_order");
  endtask

  task automatic test_shape_errors();
    logic [255:0] d;
    d = 256'h5A5A;
    do_write(32'hFEE0_0000, 8'h21, 8'd1, 3'd5, d, 32'h3,
             1'b1, 32'h0, 1'b0, 0);
    do_write(32'hFEE0_0000, 8'h22, 8'd0, 3'd5, d, 32'h1,
             1'b1, 32'h0, 1'b0, 0);
    do_write(32'hFEE0_001F, 8'h23, 8'd0, 3'd5, d, 32'h8000_0000,
             1'b1, 32'h0, 1'b0, 0);
    do_write(32'hFEE0_0000, 8'h24, 8'd0, 3'd4, d, 32'h3,
             1'b1, 32'h0, 1'b0, 0);
    do_write(32'hFEE0_0000, 8'h25, 8'd0, 3'd5, d, 32'h3,
             1'b0, 32'h0, 1'b0, 0);
    total++;
    if (msi_valid !== 1'b0)
      $display("FAIL shape_push got v=%b required 0", msi_valid);
    else passed++;
  endtask

  task automatic test_parity();
    logic [255:0] d;
    bit ok;
`ifdef MSI_PARITY_CHECK_EN
    ok = 1'b0;
`else
    ok = 1'b1;
`endif
    d = 256'h00C3_7E00 << 16;
    do_write(32'hFEE0_0003, 8'h33, 8'd0, 3'd5, d, 32'h18,
             1'b1, 32'h0000_0008, ok, 0);
    if (ok) pop_check("parity_fifo");
    total++;
    if (msi_valid !== 1'b0)
      $display("FAIL parity_drain got v=%b required 0", msi_valid);
    else passed++;
  endtask

  task automatic test_b_hold_and_reset();
    logic [255:0] d;
    d = 256'hBEEF << 80;
    do_write(32'hFEE0_000A, 8'hA7, 8'd0, 3'd5, d, 32'hC00,
             1'b1, 32'h0, 1'b1, 1);
    pop_check("hold_fifo");
    d = 256'hCAFE;
    do_write(32'hFEE0_0000, 8'h44, 8'd0, 3'd5, d, 32'h3,
             1'b1, 32'h0, 1'b1, 2);
    do_write(32'hFEE0_0000, 8'h45, 8'd0, 3'd5, d, 32'h3,
             1'b1, 32'h0, 1'b1, 0);
    pop_check("after_reset_fifo");
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 256'(16'h7700 + 16'(i)) << 16;
      do_write(32'hFEE1_0002, 8'(8'h60 + i), 8'd0, 3'd5, d, 32'hC,
               1'b1, 32'h0, 1'b1, 0);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_fifo");
  endtask

  initial begin
    test_reset();
    test_okay();
    test_bad_addr();
    test_fifo_full();
    test_shape_errors();
    test_parity();
    test_back_to_back();
    test_b_hold_and_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
